// File: rtl/vga_tile_scheduler.sv
// Tile framebuffer access scheduler: display prefetch, full-screen clear engine and host
// write port share one single-port RAM, with display reads always winning.
module vga_tile_scheduler #(
  parameter int COLS      = 80,
  parameter int ROWS      = 60,
  parameter int CELL_LOG2 = 3,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int ADDR_W    = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        next_x,
  input  logic [9:0]        next_y,
  output logic [7:0]        color_out,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_data,
  input  logic              clear_start,
  input  logic [7:0]        clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  localparam int CELLS = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  // Read three pixels before the cell boundary so the colour is ready as x enters the cell.
  localparam logic [CELL_LOG2-1:0] SLOT_PHASE = CELL_LOG2'((1 << CELL_LOG2) - 3);
  localparam logic [CELL_LOG2-1:0] LOAD_PHASE = '1;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [ADDR_W-1:0] clr_cnt_reg;
  logic [7:0]        clr_col_reg;
  logic              done_reg;
  logic              done_next;
  logic              disp_q_reg;
  logic [7:0]        next_color_reg;
  logic [7:0]        color_out_reg;
  logic              clr_load;
  logic              clr_adv;

  logic              slot;
  logic [10:0]       y_inc;
  logic [10:0]       y_wrap;
  logic [ADDR_W-1:0] col_inc;
  logic [ADDR_W-1:0] col_sel;
  logic [ADDR_W-1:0] row_sel;
  logic [ADDR_W-1:0] disp_addr;

  assign slot = (int'(next_x) < H_ACTIVE) && (next_x[CELL_LOG2-1:0] == SLOT_PHASE);

  // Lookahead cell address; the last column of a line prefetches column 0 of the next line.
  always_comb begin
    y_inc   = {1'b0, next_y} + 11'd1;
    y_wrap  = (y_inc >= 11'(V_ACTIVE)) ? (y_inc - 11'(V_ACTIVE)) : y_inc;
    col_inc = ADDR_W'(next_x >> CELL_LOG2) + ADDR_W'(1);
    if (col_inc == ADDR_W'(COLS)) begin
      col_sel = '0;
      row_sel = ADDR_W'(y_wrap >> CELL_LOG2);
    end else begin
      col_sel = col_inc;
      row_sel = ADDR_W'(next_y >> CELL_LOG2);
    end
    disp_addr = row_sel * ADDR_W'(COLS) + col_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_we     = 1'b0;
    mem_addr   = disp_addr;
    mem_wdata  = host_data;
    host_ready = 1'b0;
    clr_load   = 1'b0;
    clr_adv    = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        host_ready = rst_n && !slot;
        if (host_valid && host_ready) begin
          mem_we    = 1'b1;
          mem_addr  = host_addr;
          mem_wdata = host_data;
        end
        if (clear_start) begin
          state_next = ST_CLEAR;
          clr_load   = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (!slot) begin
          mem_we    = 1'b1;
          mem_addr  = clr_cnt_reg;
          mem_wdata = clr_col_reg;
          clr_adv   = 1'b1;
          if (clr_cnt_reg == LAST_CELL) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (!rst_n) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_reg    <= '0;
      clr_col_reg    <= '0;
      done_reg       <= 1'b0;
      disp_q_reg     <= 1'b0;
      next_color_reg <= '0;
      color_out_reg  <= '0;
    end else begin
      disp_q_reg <= slot;
      if (disp_q_reg) begin
        next_color_reg <= mem_rdata;
      end
      if (next_x[CELL_LOG2-1:0] == LOAD_PHASE) begin
        color_out_reg <= next_color_reg;
      end
      if (clr_load) begin
        clr_cnt_reg <= '0;
        clr_col_reg <= clear_color;
      end else if (clr_adv) begin
        clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
      end
      done_reg <= done_next;
    end
  end

  assign color_out  = color_out_reg;
  assign clear_busy = (state_reg == ST_CLEAR);
  assign clear_done = done_reg;

endmodule

// File: tb/tb_vga_tile_scheduler.sv
// Scoreboard bench for vga_tile_scheduler: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_vga_tile_scheduler;
  localparam int ADDR_W = 13;
  localparam int S_COLOR = 0, S_ADDR = 1, S_WE = 2, S_WDATA = 3, S_READY = 4, S_BUSY = 5, S_DONE = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [9:0]        next_x = 10'd640;
  logic [9:0]        next_y = 10'd0;
  logic [7:0]        color_out;
  logic              host_valid = 1'b0;
  logic              host_ready;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [7:0]        host_data = '0;
  logic              clear_start = 1'b0;
  logic [7:0]        clear_color = '0;
  logic              clear_busy;
  logic              clear_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;

  logic [7:0] ram [0:(1<<ADDR_W)-1];

  vga_tile_scheduler dut (
    .clk(clk), .rst_n(rst_n), .next_x(next_x), .next_y(next_y), .color_out(color_out),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr), .host_data(host_data),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
    .clear_done(clear_done), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    int cyc;
    int sig;
    int val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   px = 0;
  int   py = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int sig);
    case (sig)
      S_COLOR: return int'(color_out);
      S_ADDR:  return int'(mem_addr);
      S_WE:    return int'(mem_we);
      S_WDATA: return int'(mem_wdata);
      S_READY: return int'(host_ready);
      S_BUSY:  return int'(clear_busy);
      default: return int'(clear_done);
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      S_COLOR: return "color_out";
      S_ADDR:  return "mem_addr";
      S_WE:    return "mem_we";
      S_WDATA: return "mem_wdata";
      S_READY: return "host_ready";
      S_BUSY:  return "clear_busy";
      default: return "clear_done";
    endcase
  endfunction

  // Monitor: compares every expectation queued for the current cycle
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc != cyc)
        $display("FAIL stale_%s cycle %0d: never sampled, required %0h", sig_name(e.sig), e.cyc, e.val);
      else if (actual(e.sig) == e.val)
        n_pass++;
      else
        $display("FAIL %s cycle %0d x=%0d y=%0d: got %0h, required %0h",
                 sig_name(e.sig), cyc, next_x, next_y, actual(e.sig), e.val);
    end
  end

  task automatic expect_sig(input int sig, input int val);
    sb.push_back('{cyc, sig, val});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    host_valid  = 1'b0;
    clear_start = 1'b0;
  endtask

  function automatic bit is_slot(input int x);
    return (x < 640) && (x % 8 == 5);
  endfunction

  task automatic adv_pos();
    px++;
    if (px == 800) begin
      px = 0;
      py = (py + 1) % 525;
    end
    next_x = 10'(px);
    next_y = 10'(py);
  endtask

  task automatic host_write(input int addr, input int data);
    tick();
    next_x = 10'd640;
    next_y = 10'd0;
    host_valid = 1'b1;
    host_addr  = ADDR_W'(addr);
    host_data  = 8'(data);
    expect_sig(S_READY, 1);
    expect_sig(S_WE, 1);
    expect_sig(S_ADDR, addr);
    expect_sig(S_WDATA, data);
    $display("host write addr=%0d data=%02h", addr, data);
  endtask

  // Runs a clear already started in the previous cycle; abort_at >= 0 drops reset at that count.
  task automatic run_clear(input int col, input int abort_at, input bit hold_host);
    int  cnt = 0;
    bit  restarted = 0;
    while (cnt < 4800) begin
      tick();
      adv_pos();
      if (cnt == abort_at) begin
        rst_n = 1'b0;
        expect_sig(S_WE, 0);
        expect_sig(S_READY, 0);
        expect_sig(S_BUSY, 0);
        expect_sig(S_DONE, 0);
        expect_sig(S_COLOR, 0);
        $display("clear aborted by reset at count %0d", cnt);
        return;
      end
      if (hold_host) begin
        host_valid = 1'b1;
        host_addr  = ADDR_W'(4000);
        host_data  = 8'hAA;
      end
      if (cnt == 2000 && !restarted && abort_at < 0) begin
        clear_start = 1'b1;
        clear_color = 8'h77;
        restarted   = 1;
      end
      expect_sig(S_BUSY, 1);
      expect_sig(S_READY, 0);
      expect_sig(S_DONE, 0);
      if (is_slot(px)) begin
        expect_sig(S_WE, 0);
      end else begin
        expect_sig(S_WE, 1);
        expect_sig(S_ADDR, cnt);
        expect_sig(S_WDATA, col);
        cnt++;
      end
    end
    tick();
    adv_pos();
    expect_sig(S_DONE, 1);
    expect_sig(S_BUSY, 0);
    tick();
    adv_pos();
    expect_sig(S_DONE, 0);
    expect_sig(S_BUSY, 0);
    $display("clear colour %02h completed", col);
  endtask

  initial begin
    // Reset held with a pending host request
    host_valid = 1'b1;
    host_addr  = ADDR_W'(5);
    host_data  = 8'h01;
    @(posedge clk);
    #1;
    expect_sig(S_READY, 0);
    expect_sig(S_WE, 0);
    expect_sig(S_BUSY, 0);
    expect_sig(S_DONE, 0);
    expect_sig(S_COLOR, 0);
    tick();
    rst_n = 1'b1;
    expect_sig(S_READY, 1);
    expect_sig(S_WE, 0);
    expect_sig(S_BUSY, 0);
    expect_sig(S_DONE, 0);
    expect_sig(S_COLOR, 0);

    // Row 0: cell 0 red, cell 1 green, rest black
    for (int i = 0; i < 80; i++)
      host_write(i, (i == 0) ? 8'hE0 : (i == 1) ? 8'h1C : 8'h00);

    // Prefetch alignment sweep
    for (int x = 0; x < 640; x++) begin
      tick();
      next_x = 10'(x);
      next_y = 10'd0;
      expect_sig(S_COLOR, (x >= 8 && x < 16) ? 8'h1C : 8'h00);
      if (x == 5) begin
        expect_sig(S_ADDR, 1);
        expect_sig(S_WE, 0);
      end
    end
    $display("prefetch sweep line 0 issued");

    // Line and frame wrap, plus an interior last-column slot
    tick(); next_x = 10'd637; next_y = 10'd7;
    expect_sig(S_ADDR, 80); expect_sig(S_WE, 0); expect_sig(S_READY, 0);
    tick(); next_x = 10'd637; next_y = 10'd479;
    expect_sig(S_ADDR, 0); expect_sig(S_WE, 0);
    tick(); next_x = 10'd629; next_y = 10'd8;
    expect_sig(S_ADDR, 159); expect_sig(S_WE, 0);
    $display("wrap slots issued");

    // Arbitration: display slot blocks host, next cycle host wins
    tick(); next_x = 10'd5; next_y = 10'd0;
    host_valid = 1'b1; host_addr = ADDR_W'(100); host_data = 8'h55;
    expect_sig(S_READY, 0); expect_sig(S_WE, 0); expect_sig(S_ADDR, 1);
    tick(); next_x = 10'd6;
    host_valid = 1'b1; host_addr = ADDR_W'(100); host_data = 8'h55;
    expect_sig(S_READY, 1); expect_sig(S_WE, 1); expect_sig(S_ADDR, 100); expect_sig(S_WDATA, 8'h55);
    tick(); next_x = 10'd700;
    host_valid = 1'b1; host_addr = ADDR_W'(5000); host_data = 8'h66;
    expect_sig(S_READY, 1); expect_sig(S_WE, 1); expect_sig(S_ADDR, 5000); expect_sig(S_WDATA, 8'h66);
    $display("arbitration transactions issued");

    // Full clear with host held off and an ignored second start
    px = 600; py = 0;
    tick(); next_x = 10'(px); next_y = 10'(py);
    clear_start = 1'b1; clear_color = 8'h03;
    expect_sig(S_READY, 1); expect_sig(S_WE, 0); expect_sig(S_BUSY, 0);
    run_clear(8'h03, -1, 1'b1);

    // Clear start coinciding with a host write, then reset mid-fill
    px = 700; py = 10;
    tick(); next_x = 10'(px); next_y = 10'(py);
    clear_start = 1'b1; clear_color = 8'h0F;
    host_valid = 1'b1; host_addr = ADDR_W'(10); host_data = 8'h99;
    expect_sig(S_READY, 1); expect_sig(S_WE, 1); expect_sig(S_ADDR, 10); expect_sig(S_WDATA, 8'h99);
    expect_sig(S_BUSY, 0);
    run_clear(8'h0F, 1000, 1'b0);
    tick(); adv_pos();
    expect_sig(S_WE, 0); expect_sig(S_READY, 0); expect_sig(S_BUSY, 0);
    tick(); adv_pos();
    rst_n = 1'b1;
    expect_sig(S_READY, is_slot(px) ? 0 : 1);
    expect_sig(S_WE, 0); expect_sig(S_BUSY, 0); expect_sig(S_DONE, 0); expect_sig(S_COLOR, 0);
    tick(); adv_pos();
    expect_sig(S_WE, 0); expect_sig(S_BUSY, 0); expect_sig(S_DONE, 0);
    $display("reset released after aborted clear");

    // Cells 999 and 1000 keep the partial-fill boundary
    for (int x = 309; x <= 320; x++) begin
      tick();
      next_x = 10'(x);
      next_y = 10'd96;
      if (x == 309) begin expect_sig(S_ADDR, 999); expect_sig(S_WE, 0); end
      if (x == 317) expect_sig(S_ADDR, 1000);
      if (x == 312) expect_sig(S_COLOR, 8'h0F);
      if (x == 320) expect_sig(S_COLOR, 8'h03);
    end
    $display("readback of cells 999/1000 issued");

    repeat (3) tick();
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
